// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state codes and forward selects.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Data-memory wait FSM state codes
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    // EX-stage operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Operand forward select for one EX source register (MEM result preferred over WB result).
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of the current register tags.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       regWriteM,
    input  logic       regWriteW,
    output logic [1:0] fwd
);

    // Youngest producer wins; x0 is hard-wired zero and is never forwarded
    always_comb begin
        fwd = FWD_RF;
        if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
            fwd = FWD_MEM;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forward controller with data-memory wait FSM and timeout watchdog.
// Latency: controls are combinational from inputs and FSM state; FSM/counters update on clk.
// Backpressure: a pending memory access (or a timeout) holds every pipeline register. Optional counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             resultSrcE0,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             pcSrcE,
    input  logic             memReqM,
    input  logic             memReadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

    logic [1:0]     fsm;
    logic [1:0]     fsm_nxt;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_nxt;
    logic           in_err;
    logic           mem_stall;
    logic           lw_stall;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;

    assign in_err    = (fsm == ERROR);
    // An abort (memReqM dropped in MEM_WAIT) falls out naturally: no request, no stall
    assign mem_stall = !in_err && memReqM && !memReadyM;
    assign lw_stall  = resultSrcE0 && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    // Priority: reset > timeout > memory wait > branch > load-use
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (in_err || mem_stall) begin
            // A branch held in EX keeps its flush until EX is released
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (pcSrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lw_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Memory wait FSM next state; ERROR is left only through reset
    always_comb begin
        fsm_nxt      = fsm;
        wait_cnt_nxt = wait_cnt;
        case (fsm)
            RUN: begin
                if (mem_stall) begin
                    fsm_nxt      = MEM_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (!memReqM || memReadyM) begin
                    fsm_nxt      = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                    if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                        fsm_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                fsm_nxt = ERROR;
            end
            default: begin
                fsm_nxt      = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // FSM and wait counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm      <= RUN;
            wait_cnt <= '0;
        end else begin
            fsm      <= fsm_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign memTimeout = in_err && !reset;

    forward_unit u_fwd_a (
        .rsE       (rs1E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regWriteM (regWriteM),
        .regWriteW (regWriteW),
        .fwd       (fwd_a)
    );

    forward_unit u_fwd_b (
        .rsE       (rs2E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regWriteM (regWriteM),
        .regWriteW (regWriteW),
        .fwd       (fwd_b)
    );

    assign forwardAE = reset ? FWD_RF : fwd_a;
    assign forwardBE = reset ? FWD_RF : fwd_b;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating performance counters: decode-stall cycles and flush cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallD && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((flushD || flushE) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stallCycles = stall_cnt;
    assign flushCount  = flush_cnt;
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle hazard/forward vectors plus memory-wait sequences.
// Latency: checks sample 1-2 time units after inputs settle, away from the rising edge.
// Backpressure: memory stalls, aborts, timeout and reset-during-wait are driven by hand.
module tb_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          resultSrcE0, regWriteM, regWriteW, pcSrcE, memReqM, memReadyM;
    logic          stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0]    forwardAE, forwardBE;
    logic          memTimeout;
    logic [CW-1:0] stallCycles, flushCount;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .resultSrcE0(resultSrcE0), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .pcSrcE(pcSrcE), .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memTimeout(memTimeout),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       ld, wM, wW, br;
        logic [5:0] ctl;   // {stallF, stallD, stallE, stallM, flushD, flushE}
        logic [1:0] fa, fb;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return (n > (2**CW - 1)) ? (2**CW - 1) : n;
`else
        return (n > 0) ? 0 : 0;
`endif
    endfunction

    function automatic logic [5:0] ctl_now();
        return {stallF, stallD, stallE, stallM, flushD, flushE};
    endfunction

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        resultSrcE0 = 0; regWriteM = 0; regWriteW = 0; pcSrcE = 0;
        memReqM = 0; memReadyM = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check the forced outputs, release between edges
    task automatic do_reset(input string nm);
        reset = 1'b1;
        #1;
        chk({nm, " rst ctl"}, ctl_now(), 6'b000011);
        chk({nm, " rst fwdA"}, forwardAE, 2'b00);
        chk({nm, " rst tmo"}, memTimeout, 1'b0);
        chk({nm, " rst stallcnt"}, stallCycles, 0);
        chk({nm, " rst flushcnt"}, flushCount, 0);
        step();
        reset = 1'b0;
        #1;
    endtask

    // Hold a never-ready access and count stall cycles seen before memTimeout rises
    task automatic count_to_timeout(output int pre);
        pre = 0;
        memReqM = 1; memReadyM = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (stallD && !memTimeout) pre++;
            step();
        end
    endtask

    int pre;

    initial begin
        idle();
        // rs1D rs2D rs1E rs2E rdE rdM rdW  ld wM wW br  ctl        fa     fb
        v[0]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6'b000000, 2'b00, 2'b00};
        v[1]  = '{5, 0, 0, 0, 5, 0, 0,  1, 0, 0, 0, 6'b110001, 2'b00, 2'b00};
        v[2]  = '{0, 9, 0, 0, 9, 0, 0,  1, 0, 0, 0, 6'b110001, 2'b00, 2'b00};
        v[3]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 6'b000000, 2'b00, 2'b00};
        v[4]  = '{5, 0, 0, 0, 5, 0, 0,  0, 0, 0, 0, 6'b000000, 2'b00, 2'b00};
        v[5]  = '{5, 0, 0, 0, 5, 0, 0,  1, 0, 0, 1, 6'b000011, 2'b00, 2'b00};
        v[6]  = '{1, 2, 0, 0, 3, 0, 0,  0, 0, 0, 1, 6'b000011, 2'b00, 2'b00};
        v[7]  = '{0, 0, 7, 0, 0, 7, 7,  0, 1, 1, 0, 6'b000000, 2'b10, 2'b00};
        v[8]  = '{0, 0, 7, 0, 0, 7, 7,  0, 0, 1, 0, 6'b000000, 2'b01, 2'b00};
        v[9]  = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 6'b000000, 2'b00, 2'b00};
        v[10] = '{0, 0, 4, 3, 0, 4, 3,  0, 1, 1, 0, 6'b000000, 2'b10, 2'b01};
        v[11] = '{0, 0, 4, 3, 0, 4, 3,  0, 0, 0, 0, 6'b000000, 2'b00, 2'b00};
        v[12] = '{0, 0, 2, 2, 0, 2, 6,  0, 1, 1, 1, 6'b000011, 2'b10, 2'b10};
        v[13] = '{8, 0, 0, 6, 8, 6, 6,  1, 0, 1, 0, 6'b110001, 2'b00, 2'b01};

        // Reset state with forwarding-matching inputs: forwards must still read 00
        rdM = 7; rs1E = 7; regWriteM = 1;
        do_reset("init");
        idle();

        // Table: each vector is held for exactly one rising edge
        for (int i = 0; i < 14; i++) begin
            rs1D = v[i].rs1D; rs2D = v[i].rs2D; rs1E = v[i].rs1E; rs2E = v[i].rs2E;
            rdE = v[i].rdE; rdM = v[i].rdM; rdW = v[i].rdW;
            resultSrcE0 = v[i].ld; regWriteM = v[i].wM; regWriteW = v[i].wW; pcSrcE = v[i].br;
            #1;
            chk($sformatf("vec%0d ctl", i), ctl_now(), v[i].ctl);
            chk($sformatf("vec%0d fwdA", i), forwardAE, v[i].fa);
            chk($sformatf("vec%0d fwdB", i), forwardBE, v[i].fb);
            step();
        end
        idle();
        #1;
        chk("table stallcnt", stallCycles, cexp(3));
        chk("table flushcnt", flushCount, cexp(6));

        // Three wait cycles with a branch held in EX, then ready releases and flushes
        do_reset("seqA");
        memReqM = 1; memReadyM = 0; pcSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wait%0d ctl", i), ctl_now(), 6'b111100);
            step();
        end
        memReadyM = 1;
        #1;
        chk("ready ctl", ctl_now(), 6'b000011);
        step();
        idle();
        #1;
        chk("after ready ctl", ctl_now(), 6'b000000);
        chk("seqA stallcnt", stallCycles, cexp(3));
        chk("seqA flushcnt", flushCount, cexp(1));

        // Abort: request dropped in MEM_WAIT gives no stall, then a fresh access works
        memReqM = 1; memReadyM = 0;
        #1;
        chk("abort pre ctl", ctl_now(), 6'b111100);
        step();
        memReqM = 0;
        #1;
        chk("abort ctl", ctl_now(), 6'b000000);
        step();
        memReqM = 1; memReadyM = 1;
        #1;
        chk("abort hit ctl", ctl_now(), 6'b000000);
        step();
        idle();

        // Timeout: exactly T stall cycles before memTimeout, then stuck until reset
        do_reset("seqC");
        count_to_timeout(pre);
        chk("timeout pre-stalls", pre, T);
        chk("timeout flag", memTimeout, 1'b1);
        memReqM = 0; memReadyM = 1; pcSrcE = 1;
        #1;
        chk("error ctl", ctl_now(), 6'b111100);
        repeat (10) step();
        chk("error stuck ctl", ctl_now(), 6'b111100);
        chk("error stuck flag", memTimeout, 1'b1);
        chk("sat stallcnt", stallCycles, cexp(18));
        chk("error flushcnt", flushCount, cexp(0));
        idle();

        // Reset in the middle of MEM_WAIT abandons the access and the wait count
        do_reset("seqD");
        memReqM = 1; memReadyM = 0;
        step();
        step();
        chk("midwait stallcnt", stallCycles, cexp(2));
        rdM = 7; rs1E = 7; regWriteM = 1;
        reset = 1'b1;
        #1;
        chk("midrst ctl", ctl_now(), 6'b000011);
        chk("midrst fwdA", forwardAE, 2'b00);
        chk("midrst stallcnt", stallCycles, 0);
        reset = 1'b0;
        #1;
        chk("post rst ctl", ctl_now(), 6'b111100);
        chk("post rst tmo", memTimeout, 1'b0);
        count_to_timeout(pre);
        chk("post rst pre-stalls", pre, T);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives stall (write-enable inversion) and flush controls for the IF/ID, ID/EX and EX/MEM register banks and the PC.
- Selects EX-stage operand forwarding.
- Runs a data-memory wait FSM with a timeout watchdog; all pipeline registers are held while memory is not ready.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before ERROR (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1D, rs2D  in  5  source regs of the instruction in ID.
- rs1E, rs2E  in  5  source regs of the instruction in EX.
- rdE, rdM, rdW  in  5  destination regs in EX/MEM/WB.
- resultSrcE0  in  1  instruction in EX is a load.
- regWriteM, regWriteW  in  1  MEM/WB instruction writes the regfile.
- pcSrcE  in  1  taken branch/jump resolved in EX.
- memReqM  in  1  MEM stage issues a data-memory access.
- memReadyM  in  1  data memory completes this cycle.
- stallF, stallD, stallE, stallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM (IF-ID we = ~stallD).
- flushD, flushE  out  1  clear IF-ID / ID-EX to a bubble.
- forwardAE, forwardBE  out  2  operand select: 00 regfile, 01 WB result, 10 MEM ALU result.
- memTimeout  out  1  sticky error flag.
- stallCycles, flushCount  out  CNT_W  performance counters.

Behaviour:
- Registered state: fsm ∈ {RUN, MEM_WAIT, ERROR}; waitCnt [$clog2(MEM_TIMEOUT):0]; perf counters. All other outputs are combinational from state and inputs.
- Reset (async, immediate): fsm=RUN, waitCnt=0, counters=0. While reset is high: stalls=0, flushD=flushE=1, forward*=00, memTimeout=0.
- memStall = memReqM & ~memReadyM (RUN or MEM_WAIT).
- lwStall = resultSrcE0 & rdE≠0 & (rdE==rs1D | rdE==rs2D).
- Priority, highest first:
  - ERROR: all four stalls=1, flushes=0.
  - memStall: all four stalls=1, flushes=0; a branch in EX is held and its flush is deferred until EX advances.
  - pcSrcE: flushD=flushE=1, no stall (branch beats load-use).
  - lwStall: stallF=stallD=1, flushE=1.
  - Otherwise: all 0.
- RUN→MEM_WAIT on an edge with memStall; waitCnt=1.
- MEM_WAIT, memReadyM=1: stalls drop the same cycle; →RUN next edge; waitCnt=0.
- MEM_WAIT, memReadyM=0: waitCnt+1; when waitCnt==MEM_TIMEOUT-1 →ERROR next edge.
- Stall cycles counted before ERROR equal MEM_TIMEOUT.
- memReqM dropped while in MEM_WAIT (abort): →RUN next edge, no stall that cycle.
- ERROR: memTimeout=1; exits only via reset.
- Forwarding, per operand A/B: 10 if regWriteM & rdM≠0 & rdM==rsXE; else 01 if regWriteW & rdW≠0 & rdW==rsXE; else 00. MEM beats WB on a double match. x0 is never forwarded.
- Reset mid-MEM_WAIT: immediate return to RUN with waitCnt=0; the pending access is abandoned.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stallCycles +1 each cycle stallD=1.
  - flushCount +1 each cycle flushD|flushE=1 (a single cycle counts once).
  - Both saturate at all-ones; both cleared by reset.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg:
  - fsm state enum (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2).
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module forward_unit: purely combinational, instantiated once per operand (A, B).

Test Plan:
- rdE=5, resultSrcE0=1, rs1D=5 → stallF=stallD=flushE=1 for one cycle; same with rdE=0 → no stall.
- pcSrcE=1 with lwStall true → flushD=flushE=1, stallF=0; flushCount +1 (with macro).
- memReqM=1, memReadyM=0 for 3 cycles then 1 → stalls high for 3 cycles, low on the ready cycle; stallCycles=3.
- MEM_TIMEOUT=4, memReadyM held 0 → exactly 4 stall cycles, then memTimeout=1 and stalls stuck until reset.
- rdM=rdW=7, regWriteM=regWriteW=1, rs1E=7 → forwardAE=10; regWriteM=0 → 01; rdM=rdW=0 → 00.
- Assert reset during MEM_WAIT → flushD=flushE=1, stalls=0 immediately; after release fsm=RUN, counters=0.
